spm_mport: RTL and testbench
============================

SPM_MPORT -- requirements
Module: spm_mport

Interface
REQ-001 Parameters SHALL be: NUM_PORTS, default 2, requester count, 1..8.
REQ-002 NUM_BANKS, default 2, word-interleaved banks, power of two, 1..8.
REQ-003 ADDR_W, default 32, byte-address width per port.
REQ-004 DATA_W, default 32, data width; fixed at 32 in this generation (4 byte lanes).
REQ-005 MEMSIZE_KB, default 128, total capacity; ROWS = MEMSIZE_KB*256/NUM_BANKS words per bank.
REQ-006 READ_LAT, default 1, read latency in cycles after grant, 1 or 2.
REQ-007 Ports SHALL be:
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  pulse; re-enters memory zeroing.
- init_done  out  1  high when in READY.
- req  in  NUM_PORTS  per-port request.
- we  in  NUM_PORTS  per-port write (1) / read (0).
- be  in  NUM_PORTS*4  per-port byte enables.
- addr  in  NUM_PORTS*ADDR_W  per-port byte address, port p at [p*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  per-port write data.
- gnt  out  NUM_PORTS  per-port grant, combinational from req.
- rvalid  out  NUM_PORTS  per-port read-data strobe.
- rerr  out  NUM_PORTS  per-port out-of-range flag, qualified by rvalid.
- rdata  out  NUM_PORTS*DATA_W  per-port read data.

Function
REQ-008 Word index = addr[ADDR_W-1:2]; addr[1:0] ignored; bank = word mod NUM_BANKS; row = word / NUM_BANKS.
REQ-009 Each bank SHALL grant at most one port per cycle via round-robin; after a grant, that bank's priority pointer moves to the winner+1 (mod NUM_PORTS); pointer resets to 0.
REQ-010 Ports targeting different banks SHALL be granted in the same cycle.
REQ-011 A requester holds req, we, be, addr and wdata stable until gnt; a transfer occurs on each cycle where req and gnt are both high.
REQ-012 A granted write SHALL update only the byte lanes with be=1 at that clock edge; writes produce no rvalid.
REQ-013 A granted read SHALL assert rvalid with rdata exactly READ_LAT cycles after the grant cycle, one pulse per grant; back-to-back grants give back-to-back rvalid.
REQ-014 A read granted in the cycle after a write to the same word SHALL return the new data.
REQ-015 An access with word >= MEMSIZE_KB*256 SHALL be granted with no arbitration contention and no memory access; a read returns rdata=0 and rerr=1 at normal latency; a write is dropped silently.
REQ-016 rdata SHALL be 0 and rerr 0 whenever rvalid is 0.
REQ-017 The FSM SHALL have two states: INIT (zeroes row counter 0..ROWS-1 in all banks in parallel, one row per cycle, gnt forced to 0) and READY.
REQ-018 INIT -> READY in the cycle after row ROWS-1 is written; READY -> INIT on clr; clr during INIT restarts the counter at 0.
REQ-019 Reads already in the latency pipeline when clr is taken SHALL still complete with their captured data.
REQ-020 init_done SHALL be 1 only in READY; full zeroing takes exactly ROWS cycles.

Reset
REQ-021 On rst_n low: FSM = INIT, row counter = 0, pointers = 0, read pipeline cleared; gnt, rvalid, rerr and rdata = 0; init_done = 0.
REQ-022 Memory arrays SHALL NOT be reset by rst_n; zeroing occurs only through INIT.
REQ-023 Reset asserted mid-transfer SHALL drop all in-flight reads with no rvalid pulse.

Structure
REQ-024 Package spm_pkg SHALL hold the state enum (INIT, READY), the byte-lane constant (4), and the bank/row width helper functions.
REQ-025 Sub-module spm_rr_arb (NUM_PORTS-wide round-robin arbiter, one instance per bank) SHALL be used; storage is an inferred per-bank array, simulation model only.

Verification
REQ-026 Reset release, MEMSIZE_KB=1, NUM_BANKS=2 -> init_done rises after 128 cycles; a read of 0x10 then returns 0.
REQ-027 Port0 writes 0xDEADBEEF with be=4'b0101 at 0x8 over 0x11223344 -> read returns 0x11AD33EF.
REQ-028 Ports 0 and 1 both hold reads to bank 0 for 4 cycles -> grants alternate 0,1,0,1; each rvalid arrives READ_LAT cycles after its grant.
REQ-029 Port0 reads bank 0 while port1 reads bank 1 in the same cycle -> both granted; both rvalid in the same cycle.
REQ-030 Read of word MEMSIZE_KB*256 -> rvalid with rerr=1 and rdata=0; a write to the same word leaves memory unchanged.
REQ-031 clr pulsed while a READ_LAT=2 read is in flight -> that read completes; init_done=0 for ROWS cycles; memory then reads 0.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared definitions for the multi-port scratchpad memory.
// Holds the controller state enum, the byte-lane count, the read-return
// payload and the index-width helpers used by spm_mport and spm_rr_arb.
package spm_pkg;

    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned SPM_DATA_W = BYTE_LANES * 8;

    // Controller state: zeroing the arrays, or serving requests.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } spm_state_e;

    // One read-return beat travelling down the latency pipeline.
    typedef struct packed {
        logic                  vld;
        logic                  err;
        logic [SPM_DATA_W-1:0] data;
    } spm_rd_t;

    // Bits needed to index n items; never less than one so vectors stay legal.
    function automatic int unsigned spm_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Shift amount that strips the bank select off a word index.
    function automatic int unsigned spm_log2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

endpackage

// File: rtl/spm_rr_arb.sv
// Round-robin arbiter for one memory bank.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-port request into this bank
//   gnt_c      : one-hot grant, combinational from req and the pointer
// The priority pointer moves to winner+1 after every grant and resets to 0.
module spm_rr_arb
    import spm_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt_c
);

    localparam int unsigned PTR_W = spm_idx_w(NUM_PORTS);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;

    // Scan ports starting at the pointer; the first requester wins.
    always_comb begin : p_pick
        logic             found;
        logic [PTR_W-1:0] idx;
        gnt_c   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = PTR_W'((32'(ptr) + 32'(i)) % NUM_PORTS);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                ptr_nxt    = PTR_W'((32'(idx) + 32'd1) % NUM_PORTS);
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/spm_mport.sv
// Multi-port, word-interleaved scratchpad memory.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : pulse that re-enters memory zeroing
//   init_done  : high while serving requests (READY)
//   req/we/be/addr/wdata : per-port request bundle, held until gnt
//   gnt        : per-port grant, combinational from req
//   rvalid/rerr/rdata    : per-port read return, READ_LAT cycles after grant
// Out-of-range words are granted without arbitration; reads return rerr=1.
module spm_mport
    import spm_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEMSIZE_KB = 128,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    output logic                          init_done,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*4-1:0]        be,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    output logic [NUM_PORTS-1:0]          gnt,
    output logic [NUM_PORTS-1:0]          rvalid,
    output logic [NUM_PORTS-1:0]          rerr,
    output logic [NUM_PORTS*DATA_W-1:0]   rdata
);

    localparam int unsigned TOTAL_WORDS = MEMSIZE_KB * 256;
    localparam int unsigned ROWS        = TOTAL_WORDS / NUM_BANKS;
    localparam int unsigned BANK_W      = spm_idx_w(NUM_BANKS);
    localparam int unsigned BANK_SH     = spm_log2(NUM_BANKS);
    localparam int unsigned ROW_W       = spm_idx_w(ROWS);
    localparam int unsigned WORD_W      = ADDR_W - 2;

    spm_state_e       state;
    logic [ROW_W-1:0] init_row;
    logic             ready;

    logic [WORD_W-1:0]   p_word [NUM_PORTS];
    logic [BANK_W-1:0]   p_bank [NUM_PORTS];
    logic [ROW_W-1:0]    p_row  [NUM_PORTS];
    logic [NUM_PORTS-1:0] p_oor;
    logic [NUM_PORTS*2-1:0] unused_addr_lsb;

    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_req;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_gnt;

    logic [ROW_W-1:0]      b_row   [NUM_BANKS];
    logic [NUM_BANKS-1:0]  b_wr;
    logic [BYTE_LANES-1:0] b_be    [NUM_BANKS];
    logic [DATA_W-1:0]     b_wd    [NUM_BANKS];
    logic [DATA_W-1:0]     bank_rdata [NUM_BANKS];

    spm_rd_t rd_cap [NUM_PORTS];
    spm_rd_t rd_s1  [NUM_PORTS];
    spm_rd_t rd_out [NUM_PORTS];

    assign ready     = (state == READY);
    assign init_done = ready;

    // Controller: INIT walks every row once, READY serves until clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_row <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (clr) begin
                        init_row <= '0;
                    end else if (init_row == ROW_W'(ROWS - 1)) begin
                        state    <= READY;
                        init_row <= '0;
                    end else begin
                        init_row <= init_row + ROW_W'(1);
                    end
                end
                READY: begin
                    if (clr) begin
                        state    <= INIT;
                        init_row <= '0;
                    end
                end
                default: begin
                    state    <= INIT;
                    init_row <= '0;
                end
            endcase
        end
    end

    // Address decode: word index, bank select, row, range check.
    always_comb begin
        unused_addr_lsb = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            p_word[p] = addr[p*ADDR_W+2 +: WORD_W];
            unused_addr_lsb[p*2 +: 2] = addr[p*ADDR_W +: 2];
            p_oor[p]  = 64'(p_word[p]) >= 64'(TOTAL_WORDS);
            p_row[p]  = ROW_W'(p_word[p] >> BANK_SH);
            p_bank[p] = (NUM_BANKS == 1) ? '0 : BANK_W'(p_word[p]);
        end
    end

    // Only in-range requests contend for a bank.
    always_comb begin
        bank_req = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                bank_req[b][p] = ready && req[p] && !p_oor[p] &&
                                 (p_bank[p] == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
        spm_rr_arb #(
            .NUM_PORTS (NUM_PORTS)
        ) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (bank_req[b]),
            .gnt_c (bank_gnt[b])
        );
    end

    // Out-of-range accesses are granted immediately; nothing is granted in INIT.
    always_comb begin
        gnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ready && req[p]) begin
                gnt[p] = p_oor[p] | bank_gnt[p_bank[p]][p];
            end
        end
    end

    // Steer the winning port's request onto each bank.
    always_comb begin
        b_wr = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            b_row[b] = '0;
            b_be[b]  = '0;
            b_wd[b]  = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    b_row[b] = p_row[p];
                    b_wr[b]  = we[p];
                    b_be[b]  = be[p*BYTE_LANES +: BYTE_LANES];
                    b_wd[b]  = wdata[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Per-bank storage; contents survive rst_n and are cleared only by INIT.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [ROWS];

        always_ff @(posedge clk) begin
            if (!ready) begin
                mem[init_row] <= '0;
            end else if (b_wr[b]) begin
                for (int l = 0; l < BYTE_LANES; l++) begin
                    if (b_be[b][l]) begin
                        mem[b_row[b]][l*8 +: 8] <= b_wd[b][l*8 +: 8];
                    end
                end
            end
        end

        assign bank_rdata[b] = mem[b_row[b]];
    end

    // Capture read data at the grant edge; empty beats carry zeros.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_cap[p] = '0;
            if (gnt[p] && !we[p]) begin
                rd_cap[p].vld  = 1'b1;
                rd_cap[p].err  = p_oor[p];
                rd_cap[p].data = p_oor[p] ? '0 : bank_rdata[p_bank[p]];
            end
        end
    end

    // First latency stage; independent of state so clr never drops a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_s1[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_s1[p] <= rd_cap[p];
            end
        end
    end

    if (READ_LAT >= 2) begin : g_lat2
        spm_rd_t rd_s2 [NUM_PORTS];

        // Second latency stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    rd_s2[p] <= '0;
                end
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    rd_s2[p] <= rd_s1[p];
                end
            end
        end

        assign rd_out = rd_s2;
    end else begin : g_lat1
        assign rd_out = rd_s1;
    end

    // Unpack the final stage onto the flat output buses.
    always_comb begin
        rvalid = '0;
        rerr   = '0;
        rdata  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rvalid[p]               = rd_out[p].vld;
            rerr[p]                 = rd_out[p].err;
            rdata[p*DATA_W +: DATA_W] = rd_out[p].data;
        end
    end

endmodule

// File: tb/tb_spm_mport.sv
// Directed bench for spm_mport: 2 ports, 2 banks, 1 KB, READ_LAT=2.
module tb_spm_mport;

    localparam int unsigned NP   = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned ROWS = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              init_done;
    logic [NP-1:0]     req, we, gnt, rvalid, rerr;
    logic [NP*4-1:0]   be;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata, rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spm_mport #(
        .NUM_PORTS  (2),
        .NUM_BANKS  (2),
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEMSIZE_KB (1),
        .READ_LAT   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .init_done (init_done),
        .req       (req),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rerr      (rerr),
        .rdata     (rdata)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic [1:0]  re;
        logic [63:0] rdata;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] w,
                                input logic [7:0] b,
                                input logic [31:0] a1, input logic [31:0] a0,
                                input logic [31:0] d1, input logic [31:0] d0,
                                input logic [1:0] g, input logic [1:0] rv,
                                input logic [1:0] re,
                                input logic [31:0] r1, input logic [31:0] r0);
        vec_t v;
        v.req = rq; v.we = w; v.be = b;
        v.addr = {a1, a0}; v.wdata = {d1, d0};
        v.gnt = g; v.rv = rv; v.re = re; v.rdata = {r1, r0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    endtask

    // Counts cycles with init_done low, starting at the current sample point.
    task automatic count_init(input string name, input int pre);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 400) begin
            n++;
            @(negedge clk); #1;
        end
        chk(name, 64'(n + pre), 64'(ROWS));
    endtask

    task automatic read_chk(input int port, input logic [31:0] a,
                            input logic [31:0] exp, input string name);
        logic [1:0] onehot;
        onehot = 2'(1 << port);
        @(negedge clk);
        idle_inputs();
        req = onehot;
        addr[port*AW +: AW] = a;
        #1 chk({name, " gnt"}, 64'(gnt), 64'(onehot));
        @(negedge clk);
        idle_inputs();
        #1 chk({name, " rv_early"}, 64'(rvalid), 64'(0));
        @(negedge clk); #1;
        chk({name, " rv"}, 64'(rvalid), 64'(onehot));
        chk({name, " rerr"}, 64'(rerr), 64'(0));
        chk({name, " rdata"}, 64'(rdata[port*DW +: DW]), 64'(exp));
    endtask

    initial begin
        vt[0]  = mk(2'b10, 2'b00, 8'h00, 32'h10,  32'h0,   32'h0, 32'h0,
                    2'b10, 2'b00, 2'b00, 32'h0, 32'h0);
        vt[1]  = mk(2'b01, 2'b01, 8'h0F, 32'h0,   32'h8,   32'h0, 32'h11223344,
                    2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
        vt[2]  = mk(2'b01, 2'b01, 8'h05, 32'h0,   32'h8,   32'h0, 32'hDEADBEEF,
                    2'b01, 2'b10, 2'b00, 32'h0, 32'h0);
        vt[3]  = mk(2'b01, 2'b00, 8'h00, 32'h0,   32'h8,   32'h0, 32'h0,
                    2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
        vt[4]  = mk(2'b11, 2'b11, 8'hFF, 32'h10,  32'h4,   32'h0BADC0DE, 32'hCAFEF00D,
                    2'b11, 2'b00, 2'b00, 32'h0, 32'h0);
        vt[5]  = mk(2'b11, 2'b00, 8'h00, 32'h10,  32'h4,   32'h0, 32'h0,
                    2'b11, 2'b01, 2'b00, 32'h0, 32'h11AD33EF);
        vt[6]  = mk(2'b00, 2'b00, 8'h00, 32'h0,   32'h0,   32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        vt[7]  = mk(2'b11, 2'b00, 8'h00, 32'h10,  32'h8,   32'h0, 32'h0,
                    2'b01, 2'b11, 2'b00, 32'h0BADC0DE, 32'hCAFEF00D);
        vt[8]  = mk(2'b11, 2'b00, 8'h00, 32'h10,  32'h8,   32'h0, 32'h0,
                    2'b10, 2'b00, 2'b00, 32'h0, 32'h0);
        vt[9]  = mk(2'b11, 2'b00, 8'h00, 32'h10,  32'h8,   32'h0, 32'h0,
                    2'b01, 2'b01, 2'b00, 32'h0, 32'h11AD33EF);
        vt[10] = mk(2'b11, 2'b00, 8'h00, 32'h10,  32'h8,   32'h0, 32'h0,
                    2'b10, 2'b10, 2'b00, 32'h0BADC0DE, 32'h0);
        vt[11] = mk(2'b11, 2'b10, 8'hF0, 32'h400, 32'h400, 32'hFFFFFFFF, 32'h0,
                    2'b11, 2'b01, 2'b00, 32'h0, 32'h11AD33EF);
        vt[12] = mk(2'b01, 2'b00, 8'h00, 32'h0,   32'h0,   32'h0, 32'h0,
                    2'b01, 2'b10, 2'b00, 32'h0BADC0DE, 32'h0);
        vt[13] = mk(2'b00, 2'b00, 8'h00, 32'h0,   32'h0,   32'h0, 32'h0,
                    2'b00, 2'b01, 2'b01, 32'h0, 32'h0);
        vt[14] = mk(2'b00, 2'b00, 8'h00, 32'h0,   32'h0,   32'h0, 32'h0,
                    2'b00, 2'b01, 2'b00, 32'h0, 32'h0);
        vt[15] = mk(2'b00, 2'b00, 8'h00, 32'h0,   32'h0,   32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 32'h0, 32'h0);

        // Reset state, with requests asserted to show gnt is held low.
        rst_n = 1'b0;
        clr   = 1'b0;
        idle_inputs();
        req   = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("rst gnt",       64'(gnt),       64'(0));
        chk("rst rvalid",    64'(rvalid),    64'(0));
        chk("rst rerr",      64'(rerr),      64'(0));
        chk("rst rdata",     64'(rdata),     64'(0));
        chk("rst init_done", 64'(init_done), 64'(0));

        // Reset release: zeroing takes ROWS cycles.
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1 count_init("init_after_reset", 0);

        // clr from READY, then clr again mid-INIT restarts the row counter.
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        repeat (40) @(negedge clk);
        #1 chk("init_mid low", 64'(init_done), 64'(0));
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        #1 count_init("init_restart", 0);

        // Cycle-by-cycle table.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req   = vt[i].req;
            we    = vt[i].we;
            be    = vt[i].be;
            addr  = vt[i].addr;
            wdata = vt[i].wdata;
            #1;
            chk($sformatf("v%0d gnt", i),    64'(gnt),    64'(vt[i].gnt));
            chk($sformatf("v%0d rvalid", i), 64'(rvalid), 64'(vt[i].rv));
            chk($sformatf("v%0d rerr", i),   64'(rerr),   64'(vt[i].re));
            chk($sformatf("v%0d rdata", i),  64'(rdata),  vt[i].rdata);
        end

        // clr while a read is in flight: the read still returns its data.
        @(negedge clk);
        idle_inputs();
        req  = 2'b01;
        addr = 64'h8;
        clr  = 1'b1;
        #1;
        chk("clr gnt", 64'(gnt), 64'(1));
        chk("clr init_done_before", 64'(init_done), 64'(1));
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr gnt_in_init", 64'(gnt), 64'(0));
        chk("clr rv_early", 64'(rvalid), 64'(0));
        chk("clr init_done_low", 64'(init_done), 64'(0));
        @(negedge clk);
        idle_inputs();
        #1;
        chk("clr rv", 64'(rvalid), 64'(1));
        chk("clr rdata", 64'(rdata), 64'(32'h11AD33EF));
        count_init("clr_init_len", 1);

        // Memory zeroed by the clr.
        read_chk(0, 32'h8,  32'h0, "post_clr w2");
        read_chk(1, 32'h4,  32'h0, "post_clr w1");

        // Reset mid-transfer drops the in-flight read.
        @(negedge clk);
        idle_inputs();
        req  = 2'b01;
        addr = 64'h10;
        #1 chk("rst_mid gnt", 64'(gnt), 64'(1));
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1 chk("rst_mid rv0", 64'(rvalid), 64'(0));
        @(negedge clk);
        #1 chk("rst_mid rv1", 64'(rvalid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 count_init("init_after_rst_mid", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
